// File: rtl/cpri_sched_pkg.sv
// Shared types and constants for the CPRI receive read scheduler.
package cpri_sched_pkg;

    localparam int CHIP_WORDS      = 84;
    localparam int CHIP_FIRST_ADDR = 7;
    localparam int LANE_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic              vld;
        logic              sop;
        logic              eop;
        logic [LANE_W-1:0] lane;
    } beat_tag_t;

endpackage

// File: rtl/cpri_rx_sched_rr_arbiter.sv
// Round-robin find-first-set: searches req starting one past ptr, wrapping, and
// returns the winning index plus an any-request flag. Purely combinational.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] idx,
    output logic             any
);

    logic [PTR_W-1:0] cand_s;

    assign any = |req;

    // Walk from the farthest candidate to the nearest so the nearest hit wins
    always_comb begin
        idx    = '0;
        cand_s = '0;
        for (int i = N; i >= 1; i--) begin
            cand_s = PTR_W'((int'(ptr) + i) % N);
            if (req[cand_s]) begin
                idx = cand_s;
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/cpri_rx_sched.sv
// Shares one downstream consumer among NUM_LANES CPRI RX loop buffers, reading
// one whole chip per grant in round-robin order and tagging the merged stream.
module cpri_rx_sched #(
    parameter int NUM_LANES    = 4,
    parameter int CHIP_WORDS   = cpri_sched_pkg::CHIP_WORDS,
    parameter int READ_LATENCY = 3,
    parameter int DATA_WIDTH   = 64,
    parameter int INFO_WIDTH   = 256
) (
    input  logic                             rd_clk,
    input  logic                             rd_rst_n,
    input  logic [NUM_LANES-1:0]             i_lane_en,
    input  logic [NUM_LANES-1:0]             i_lane_avail,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  i_lane_data,
    input  logic [NUM_LANES*INFO_WIDTH-1:0]  i_lane_info,
    input  logic                             i_ds_ready,
    output logic [NUM_LANES-1:0]             o_rready,
    output logic                             o_valid,
    output logic                             o_sop,
    output logic                             o_eop,
    output logic [2:0]                       o_lane_id,
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic [INFO_WIDTH-1:0]            o_info,
    output logic                             o_busy
);
    import cpri_sched_pkg::*;

    localparam int PTR_W = $clog2(NUM_LANES);
    localparam int CNT_W = $clog2(CHIP_WORDS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CHIP_WORDS - 1);

    sched_state_t          state_r;
    logic [PTR_W-1:0]      rr_ptr_r;
    logic [PTR_W-1:0]      gnt_r;
    logic [CNT_W-1:0]      beat_cnt_r;
    logic [NUM_LANES-1:0]  req_s;
    logic [PTR_W-1:0]      arb_idx_s;
    logic                  arb_any_s;
    logic                  rd_beat_s;
    beat_tag_t             tag_in_s;
    beat_tag_t             tag_out_s;
    beat_tag_t             tag_r [READ_LATENCY];
    logic [DATA_WIDTH-1:0] lane_data_s;
    logic [INFO_WIDTH-1:0] lane_info_s;
    logic [INFO_WIDTH-1:0] info_r;

    assign req_s = i_lane_en & i_lane_avail;

    rr_arbiter #(
        .N     (NUM_LANES),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (req_s),
        .ptr (rr_ptr_r),
        .idx (arb_idx_s),
        .any (arb_any_s)
    );

    // Read enable follows downstream ready in the same cycle so a stall stops reads at once
    always_comb begin
        o_rready  = '0;
        rd_beat_s = 1'b0;
        if (state_r == ST_BURST) begin
            rd_beat_s       = i_ds_ready;
            o_rready[gnt_r] = i_ds_ready;
        end else begin
            rd_beat_s = 1'b0;
        end
    end

    // Scheduler FSM: pick a lane, read exactly one chip from it, then pause one cycle
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= PTR_W'(NUM_LANES - 1);
            gnt_r      <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (|req_s) begin
                        state_r <= ST_ARB;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARB: begin
                    if (arb_any_s) begin
                        gnt_r      <= arb_idx_s;
                        beat_cnt_r <= '0;
                        state_r    <= ST_BURST;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (rd_beat_s && (beat_cnt_r == LAST_BEAT)) begin
                        rr_ptr_r <= gnt_r;
                        state_r  <= ST_GAP;
                    end else if (rd_beat_s) begin
                        beat_cnt_r <= beat_cnt_r + CNT_W'(1);
                    end else begin
                        beat_cnt_r <= beat_cnt_r;
                    end
                end
                ST_GAP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag describing the beat being read this cycle
    always_comb begin
        tag_in_s = '0;
        if (rd_beat_s) begin
            tag_in_s.vld  = 1'b1;
            tag_in_s.sop  = (beat_cnt_r == '0);
            tag_in_s.eop  = (beat_cnt_r == LAST_BEAT);
            tag_in_s.lane = LANE_W'(gnt_r);
        end else begin
            tag_in_s = '0;
        end
    end

    // Delay the tag by the lane read latency so it lines up with the returned word
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                tag_r[i] <= '0;
            end
        end else begin
            tag_r[0] <= tag_in_s;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    assign tag_out_s = tag_r[READ_LATENCY-1];

    // Select the returning lane's word and header
    always_comb begin
        lane_data_s = '0;
        lane_info_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_data_s = (int'(tag_out_s.lane) == i) ? i_lane_data[i*DATA_WIDTH +: DATA_WIDTH] : lane_data_s;
            lane_info_s = (int'(tag_out_s.lane) == i) ? i_lane_info[i*INFO_WIDTH +: INFO_WIDTH] : lane_info_s;
        end
    end

    // Header is taken on the sop beat and held for the rest of the chip
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            info_r <= '0;
        end else if (tag_out_s.vld && tag_out_s.sop) begin
            info_r <= lane_info_s;
        end else begin
            info_r <= info_r;
        end
    end

    assign o_valid   = tag_out_s.vld;
    assign o_sop     = tag_out_s.sop;
    assign o_eop     = tag_out_s.eop;
    assign o_lane_id = tag_out_s.lane;
    assign o_data    = tag_out_s.vld ? lane_data_s : '0;
    assign o_info    = (tag_out_s.vld && tag_out_s.sop) ? lane_info_s : info_r;
    assign o_busy    = (state_r != ST_IDLE);

endmodule

// File: tb/tb_cpri_rx_sched.sv
// Directed bench for cpri_rx_sched: lane buffer emulators, a cycle-level
// behavioural scheduler model with per-cycle comparison, and literal checks.
module tb_cpri_rx_sched;

    localparam int NL = 4;
    localparam int CW = 84;
    localparam int RL = 3;
    localparam int DW = 64;
    localparam int IW = 256;

    logic              rd_clk = 1'b0;
    logic              rd_rst_n = 1'b0;
    logic [NL-1:0]     lane_en;
    logic [NL-1:0]     lane_avail;
    logic [NL*DW-1:0]  lane_data = '0;
    logic [NL*IW-1:0]  lane_info = '0;
    logic              ds_ready;
    logic [NL-1:0]     o_rready;
    logic              o_valid, o_sop, o_eop, o_busy;
    logic [2:0]        o_lane_id;
    logic [DW-1:0]     o_data;
    logic [IW-1:0]     o_info;

    cpri_rx_sched #(
        .NUM_LANES(NL), .CHIP_WORDS(CW), .READ_LATENCY(RL), .DATA_WIDTH(DW), .INFO_WIDTH(IW)
    ) dut (
        .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .i_lane_en(lane_en), .i_lane_avail(lane_avail),
        .i_lane_data(lane_data), .i_lane_info(lane_info), .i_ds_ready(ds_ready),
        .o_rready(o_rready), .o_valid(o_valid), .o_sop(o_sop), .o_eop(o_eop),
        .o_lane_id(o_lane_id), .o_data(o_data), .o_info(o_info), .o_busy(o_busy)
    );

    always #5 rd_clk = ~rd_clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    endtask

    function automatic logic [DW-1:0] word(input int l, input int chip, input int beat);
        return {8'(l), 24'(chip), 32'(7 + beat)};
    endfunction

    function automatic logic [IW-1:0] hdr(input int l, input int chip);
        return {224'd0, 8'(l), 24'(chip)};
    endfunction

    function automatic int pick(input logic [NL-1:0] r, input int last);
        for (int k = 1; k <= NL; k++) if (r[(last + k) % NL]) return (last + k) % NL;
        return -1;
    endfunction

    // Lane buffer emulators: each read returns the next word of the current chip RL cycles later
    logic [DW-1:0] lpipe [NL][RL];
    int            lptr  [NL] = '{default: 0};
    int            lchip [NL] = '{default: 0};
    logic [NL-1:0] rr_snap = '0;

    always @(posedge rd_clk) begin
        #1;
        for (int l = 0; l < NL; l++) begin
            if (!rd_rst_n) begin
                lptr[l] = 0;
                for (int s = 0; s < RL; s++) lpipe[l][s] = '0;
            end else begin
                for (int s = RL - 1; s > 0; s--) lpipe[l][s] = lpipe[l][s-1];
                if (rr_snap[l]) begin
                    lpipe[l][0] = word(l, lchip[l], lptr[l]);
                    lptr[l]++;
                    if (lptr[l] == CW) begin
                        lptr[l] = 0;
                        lchip[l]++;
                    end
                end else begin
                    lpipe[l][0] = 64'hDEAD_0000_0000_0000;
                end
            end
            lane_data[l*DW +: DW] = lpipe[l][RL-1];
            lane_info[l*IW +: IW] = {224'd0, lpipe[l][RL-1][63:32]};
        end
    end

    // Behavioural model state: which lane is being served, beats done, when it may look again
    typedef struct packed { bit sop; bit eop; int lane; int chip; int beat; } ev_t;
    ev_t exp_out [int];
    int  m_lane = -1, m_beat = 0, m_last = NL - 1, m_arb = -1, m_free = 0, m_gap = -1;
    int  m_chip [NL] = '{default: 0};
    logic [IW-1:0] m_info = '0;

    // Observation statistics for the literal checks
    int rr_cnt [NL];
    int rr_total, first_rr, last_rr, vld_cnt, first_vld, last_vld, eop_cnt, last_eop, busy_cnt;
    int sop_cyc_q [$];
    int sop_lane_q [$];

    task automatic clear_stats();
        for (int l = 0; l < NL; l++) rr_cnt[l] = 0;
        rr_total = 0; first_rr = -1; last_rr = -1; vld_cnt = 0; first_vld = -1;
        last_vld = -1; eop_cnt = 0; last_eop = -1; busy_cnt = 0;
        sop_cyc_q.delete(); sop_lane_q.delete();
    endtask

    always @(negedge rd_clk) begin
        logic [NL-1:0] req, e_rr;
        bit            e_busy, has;
        ev_t           ev;
        rr_snap = o_rready;
        if (!rd_rst_n) begin
            m_lane = -1; m_beat = 0; m_last = NL - 1; m_arb = -1; m_free = cyc + 1; m_gap = -1;
            m_info = '0;
            exp_out.delete();
            chk("rst_rready", o_rready, '0);
            chk("rst_valid", o_valid, '0);
            chk("rst_busy", o_busy, '0);
            chk("rst_sop_eop_lane", {o_sop, o_eop, o_lane_id}, '0);
            chk("rst_data", o_data, '0);
            chk("rst_info", o_info, '0);
        end else begin
            req    = lane_en & lane_avail;
            e_rr   = '0;
            e_busy = (m_arb == cyc) || (m_lane >= 0) || (m_gap == cyc);
            if (m_lane >= 0) begin
                if (ds_ready) begin
                    e_rr[m_lane] = 1'b1;
                    ev.sop = (m_beat == 0); ev.eop = (m_beat == CW - 1);
                    ev.lane = m_lane; ev.chip = m_chip[m_lane]; ev.beat = m_beat;
                    exp_out[cyc + RL] = ev;
                    m_beat++;
                    if (m_beat == CW) begin
                        m_last = m_lane; m_chip[m_lane]++; m_lane = -1;
                        m_gap = cyc + 1; m_free = cyc + 2;
                    end
                end
            end else if (m_arb == cyc) begin
                m_arb = -1;
                if (req != '0) begin
                    m_lane = pick(req, m_last); m_beat = 0;
                end else begin
                    m_free = cyc + 1;
                end
            end else if (m_arb < 0 && cyc >= m_free && req != '0) begin
                m_arb = cyc + 1;
            end
            has = exp_out.exists(cyc);
            chk("rready", o_rready, e_rr);
            chk("rready_onehot", IW'($countones(o_rready) <= 1), 1);
            chk("busy", o_busy, e_busy);
            chk("valid", o_valid, has);
            if (has) begin
                ev = exp_out[cyc];
                exp_out.delete(cyc);
                chk("sop", o_sop, ev.sop);
                chk("eop", o_eop, ev.eop);
                chk("lane_id", o_lane_id, ev.lane);
                chk("data", o_data, word(ev.lane, ev.chip, ev.beat));
                if (ev.sop) m_info = hdr(ev.lane, ev.chip);
            end else begin
                chk("idle_sop_eop", {o_sop, o_eop}, '0);
            end
            chk("info", o_info, m_info);
            for (int l = 0; l < NL; l++) begin
                if (o_rready[l]) begin
                    rr_cnt[l]++; rr_total++;
                    if (first_rr < 0) first_rr = cyc;
                    last_rr = cyc;
                end
            end
            if (o_busy) busy_cnt++;
            if (o_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
                last_vld = cyc;
                if (o_sop) begin sop_cyc_q.push_back(cyc); sop_lane_q.push_back(int'(o_lane_id)); end
                if (o_eop) begin eop_cnt++; last_eop = cyc; end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_eops(input int n, input int budget);
        int k = 0;
        while (eop_cnt < n && k < budget) begin @(negedge rd_clk); k++; end
        chk("wait_eop", eop_cnt, n);
    endtask

    task automatic wait_sops(input int n, input int budget);
        int k = 0;
        while (sop_lane_q.size() < n && k < budget) begin @(negedge rd_clk); k++; end
        chk("wait_sop", sop_lane_q.size(), n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin
        int t0, k;
        lane_en = '1; lane_avail = '0; ds_ready = 1'b1; rd_rst_n = 1'b0;
        clear_stats();
        repeat (2) tick();
        @(negedge rd_clk);
        chk("reset_state", {o_valid, o_sop, o_eop, o_busy, o_rready, o_lane_id}, '0);
        tick(); rd_rst_n = 1'b1;

        // Nothing available, then enabled-off availability, then a one-cycle request blip
        repeat (10) tick();
        lane_en = 4'b0000; lane_avail = 4'b0001;
        repeat (5) tick();
        chk("noreq_busy_cnt", busy_cnt, 0);
        lane_en = '1;
        tick(); lane_avail = '0;
        repeat (10) tick();
        chk("blip_rready_cnt", rr_total, 0);
        chk("blip_busy_cnt", busy_cnt, 1);

        // Single lane 2 for one chip
        clear_stats();
        t0 = cyc; lane_avail = 4'b0100;
        repeat (20) tick();
        lane_avail = '0;
        wait_eops(1, 300);
        repeat (5) tick();
        chk("t1_req_to_rready", first_rr - t0, 2);
        chk("t1_rready_cnt", rr_cnt[2], CW);
        chk("t1_rready_span", last_rr - first_rr, CW - 1);
        chk("t1_valid_cnt", vld_cnt, CW);
        chk("t1_rready_to_valid", first_vld - first_rr, RL);
        chk("t1_sop_lane", sop_lane_q[0], 2);
        chk("t1_sop_first", sop_cyc_q[0], first_vld);
        chk("t1_eop_last", last_eop, last_vld);

        // All lanes available from reset: order 0,1,2,3,0 with 87-cycle period
        tick(); rd_rst_n = 1'b0;
        repeat (2) tick();
        rd_rst_n = 1'b1;
        clear_stats();
        t0 = cyc; lane_avail = 4'b1111;
        wait_sops(5, 600);
        tick(); lane_avail = '0;
        wait_eops(5, 300);
        repeat (5) tick();
        chk("t2_req_to_rready", first_rr - t0, 2);
        chk("t2_order", {8'(sop_lane_q[0]), 8'(sop_lane_q[1]), 8'(sop_lane_q[2]), 8'(sop_lane_q[3]), 8'(sop_lane_q[4])},
            40'h00_01_02_03_00);
        for (int i = 1; i < 5; i++) chk("t2_sop_period", sop_cyc_q[i] - sop_cyc_q[i-1], 87);

        // Downstream stall of 10 cycles at beat 40 on lane 1
        clear_stats();
        lane_avail = 4'b0010;
        k = 0;
        while (rr_cnt[1] < 40 && k < 200) begin @(negedge rd_clk); k++; end
        chk("t3_reach_beat40", rr_cnt[1], 40);
        tick(); ds_ready = 1'b0; lane_avail = '0;
        repeat (10) tick();
        ds_ready = 1'b1;
        wait_eops(1, 300);
        repeat (5) tick();
        chk("t3_rready_cnt", rr_cnt[1], CW);
        chk("t3_rready_span", last_rr - first_rr, CW + 10 - 1);
        chk("t3_valid_cnt", vld_cnt, CW);
        chk("t3_valid_span", last_vld - first_vld, CW + 10 - 1);
        chk("t3_eop_last", last_eop, last_vld);

        // Lane 1 disabled mid-burst: burst completes, lane 1 is not granted again
        clear_stats();
        lane_avail = 4'b0010;
        k = 0;
        while (rr_cnt[1] < 20 && k < 200) begin @(negedge rd_clk); k++; end
        tick(); lane_en = 4'b1101;
        wait_eops(1, 300);
        repeat (20) tick();
        chk("t4_lane1_beats", rr_cnt[1], CW);
        chk("t4_lane1_eop_cnt", eop_cnt, 1);
        lane_avail = 4'b0011;
        wait_sops(2, 300);
        tick(); lane_avail = '0;
        wait_eops(2, 300);
        chk("t4_next_grant", sop_lane_q[1], 0);
        chk("t4_lane1_beats_after", rr_cnt[1], CW);
        lane_en = '1;
        repeat (5) tick();

        // Reset pulsed at beat 30: outputs drop at once, lane 0 served first afterwards
        clear_stats();
        lane_avail = 4'b1111;
        k = 0;
        while (rr_total < 30 && k < 200) begin @(negedge rd_clk); k++; end
        chk("t5_reach_beat30", rr_total, 30);
        tick(); rd_rst_n = 1'b0;
        @(negedge rd_clk);
        chk("t5_rst_rready", o_rready, '0);
        chk("t5_rst_valid", o_valid, '0);
        repeat (2) tick();
        rd_rst_n = 1'b1;
        clear_stats();
        t0 = cyc;
        wait_sops(1, 100);
        tick(); lane_avail = '0;
        wait_eops(1, 300);
        repeat (5) tick();
        chk("t5_first_grant", sop_lane_q[0], 0);
        chk("t5_req_to_rready", first_rr - t0, 2);
        chk("t5_beats", rr_cnt[0], CW);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
